// File: rtl/iomem_uart_tx_if.sv
// iomem native bus: valid/ready handshake, 32-bit address/data, byte write strobes.
// The initiator (CPU side) holds valid until ready; the responder pulses ready for one cycle.
interface iomem_uart_tx_if;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [31:0] iomem_addr;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    modport master (
        output iomem_valid, iomem_addr, iomem_wstrb, iomem_wdata,
        input  iomem_ready, iomem_rdata
    );

    modport slave (
        input  iomem_valid, iomem_addr, iomem_wstrb, iomem_wdata,
        output iomem_ready, iomem_rdata
    );
endinterface

// File: rtl/iomem_uart_tx.sv
// iomem-mapped 8N1 UART transmitter: DIV/DATA/STATUS register window, small TX FIFO,
// and a shifter that chains frames back to back while the FIFO has data.
module iomem_uart_tx #(
    parameter int DEFAULT_DIV = 104,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic           clk,
    input  logic           resetn,
    iomem_uart_tx_if.slave bus,
    output logic           ser_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_SPACE, ACK} state_t;

    state_t        state;
    logic [15:0]   div, div_wr;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          empty, full, push, pop;
    logic [1:0]    sel;
    logic          is_push, is_write;
    logic [31:0]   rd_mux;

    logic          busy;
    logic [15:0]   sdiv, cnt;
    logic [3:0]    bidx;
    logic [7:0]    shreg;
    logic          last_cyc, frame_end;

    logic          unused_bits;
    assign unused_bits = ^{bus.iomem_addr[31:4], bus.iomem_addr[1:0], bus.iomem_wdata[31:16]};

    assign sel      = bus.iomem_addr[3:2];
    assign is_write = |bus.iomem_wstrb;
    assign is_push  = (sel == 2'd1) && bus.iomem_wstrb[0];
    assign empty    = (level == '0);
    assign full     = (level == (AW+1)'(FIFO_DEPTH));

    // A stalled push may land on the same edge the shifter frees a slot.
    assign push = bus.iomem_valid && is_push &&
                  ((state == IDLE && !full) || (state == WAIT_SPACE && (!full || pop)));

    assign last_cyc  = (cnt == sdiv - 16'd1);
    assign frame_end = busy && (bidx == 4'd9) && last_cyc;
    assign pop       = !empty && (!busy || frame_end);

    always_comb begin
        div_wr = div;
        if (bus.iomem_wstrb[0]) div_wr[7:0]  = bus.iomem_wdata[7:0];
        if (bus.iomem_wstrb[1]) div_wr[15:8] = bus.iomem_wdata[15:8];
        if (div_wr < 16'd2)     div_wr = 16'd2;
    end

    always_comb begin
        rd_mux = 32'h0;
        case (sel)
            2'd0:    rd_mux = {16'h0, div};
            2'd2:    rd_mux = {16'h0, 8'(level), 5'b0, busy, full, empty};
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state           <= IDLE;
            bus.iomem_ready <= 1'b0;
            bus.iomem_rdata <= 32'h0;
            div             <= 16'(DEFAULT_DIV);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iomem_valid) begin
                        if (is_push && full) begin
                            state <= WAIT_SPACE;
                        end else begin
                            state           <= ACK;
                            bus.iomem_ready <= 1'b1;
                            bus.iomem_rdata <= rd_mux;
                            if (sel == 2'd0 && is_write) div <= div_wr;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (!full || pop) begin
                        state           <= ACK;
                        bus.iomem_ready <= 1'b1;
                        bus.iomem_rdata <= rd_mux;
                    end
                end
                ACK: begin
                    state           <= IDLE;
                    bus.iomem_ready <= 1'b0;
                    bus.iomem_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.iomem_wdata[7:0];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // bidx: 0 start, 1..8 data LSB first, 9 stop; the divider is frozen per frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy   <= 1'b0;
            sdiv   <= 16'd2;
            cnt    <= 16'd0;
            bidx   <= 4'd0;
            shreg  <= 8'h0;
            ser_tx <= 1'b1;
        end else if (pop) begin
            busy   <= 1'b1;
            sdiv   <= div;
            cnt    <= 16'd0;
            bidx   <= 4'd0;
            shreg  <= mem[rd_ptr];
            ser_tx <= 1'b0;
        end else if (busy) begin
            if (last_cyc) begin
                cnt <= 16'd0;
                if (bidx == 4'd9) begin
                    busy <= 1'b0;
                end else begin
                    bidx <= bidx + 4'd1;
                    if (bidx == 4'd8) begin
                        ser_tx <= 1'b1;
                    end else begin
                        ser_tx <= shreg[0];
                        shreg  <= shreg >> 1;
                    end
                end
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_iomem_uart_tx.sv
// Bench for iomem_uart_tx: register vectors from a table, a serial-line monitor feeding a
// frame queue, and an expected-byte scoreboard filled as DATA writes are driven.
module tb_iomem_uart_tx;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic ser_tx;

    iomem_uart_tx_if bif();

    iomem_uart_tx #(.DEFAULT_DIV(104), .FIFO_DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif),
        .ser_tx (ser_tx)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0]  data;
        logic        ok;
        int unsigned start;
    } frame_t;

    frame_t     rx_q[$];
    logic [7:0] exp_q[$];
    int         mon_div = 104;
    int unsigned prev_start, last_start;

    // Serial monitor: every cycle of every bit must hold the level seen on the bit's first cycle.
    logic        mon_act = 1'b0;
    logic [3:0]  mon_bit;
    int          mon_cnt;
    logic        mon_lvl, mon_ok;
    logic [7:0]  mon_data;
    int unsigned mon_start;

    always @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            mon_act <= 1'b0;
        end else if (!mon_act) begin
            if (ser_tx == 1'b0) begin
                mon_act   <= 1'b1;
                mon_bit   <= 4'd0;
                mon_cnt   <= 1;
                mon_lvl   <= 1'b0;
                mon_ok    <= 1'b1;
                mon_data  <= 8'h0;
                mon_start <= cyc;
            end
        end else begin
            if (mon_cnt == 0) begin
                mon_lvl <= ser_tx;
                if (mon_bit >= 4'd1 && mon_bit <= 4'd8) mon_data[3'(mon_bit - 4'd1)] <= ser_tx;
                if (mon_bit == 4'd9 && !ser_tx) mon_ok <= 1'b0;
            end else if (ser_tx != mon_lvl) begin
                mon_ok <= 1'b0;
            end
            if (mon_cnt == mon_div - 1) begin
                mon_cnt <= 0;
                if (mon_bit == 4'd9) begin
                    rx_q.push_back('{mon_data, mon_ok && (ser_tx == mon_lvl), mon_start});
                    mon_act <= 1'b0;
                end else begin
                    mon_bit <= mon_bit + 4'd1;
                end
            end else begin
                mon_cnt <= mon_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where ready is seen. n = -1 on timeout.
    task automatic bus_xfer(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                            output logic [31:0] rd, output int n);
        if (ws[0] && a[3:2] == 2'd1) exp_q.push_back(wd[7:0]);
        bif.iomem_valid = 1'b1;
        bif.iomem_addr  = a;
        bif.iomem_wstrb = ws;
        bif.iomem_wdata = wd;
        rd = 32'h0;
        n  = -1;
        for (int i = 1; i <= 3000; i++) begin
            @(negedge clk);
            if (bif.iomem_ready) begin
                rd = bif.iomem_rdata;
                n  = i;
                break;
            end
        end
        bif.iomem_valid = 1'b0;
        bif.iomem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd);
        logic [31:0] rd;
        int n;
        bus_xfer(a, ws, wd, rd, n);
        chk($sformatf("write ack latency a=%0h", a), 32'(n >= 1 && n <= 2), 32'd1);
    endtask

    task automatic rdchk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int n;
        bus_xfer(a, 4'h0, 32'h0, rd, n);
        chk({name, " ack"}, 32'(n >= 1 && n <= 2), 32'd1);
        chk(name, rd, exp);
    endtask

    task automatic wait_frames(input int nf, input int bound);
        for (int i = 0; i < bound && rx_q.size() < nf; i++) @(negedge clk);
        chk("frame count", rx_q.size(), nf);
        while (rx_q.size() > 0) begin
            frame_t f;
            f = rx_q.pop_front();
            prev_start = last_start;
            last_start = f.start;
            chk("frame timing/shape", 32'(f.ok), 32'd1);
            if (exp_q.size() == 0) chk("unexpected frame", 32'(f.data), 32'hxxxx_xxxx);
            else chk("frame byte", 32'(f.data), 32'(exp_q.pop_front()));
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic [31:0] rd;
        int n;

        vecs[0]  = '{32'h8,  4'h0, 32'h0,         32'h0000_0001};
        vecs[1]  = '{32'h0,  4'h0, 32'h0,         32'd104};
        vecs[2]  = '{32'h4,  4'h0, 32'h0,         32'h0};
        vecs[3]  = '{32'hC,  4'h0, 32'h0,         32'h0};
        vecs[4]  = '{32'h0,  4'h1, 32'h0000_0001, 32'h0};
        vecs[5]  = '{32'h0,  4'h0, 32'h0,         32'h2};
        vecs[6]  = '{32'h0,  4'h2, 32'h0000_1200, 32'h0};
        vecs[7]  = '{32'h0,  4'h0, 32'h0,         32'h1202};
        vecs[8]  = '{32'hC,  4'hF, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{32'h0,  4'h0, 32'h0,         32'h1202};
        vecs[10] = '{32'h0,  4'hC, 32'hFFFF_0000, 32'h0};
        vecs[11] = '{32'h0,  4'h0, 32'h0,         32'h1202};
        vecs[12] = '{32'h4,  4'h2, 32'h0000_55AA, 32'h0};
        vecs[13] = '{32'h8,  4'h0, 32'h0,         32'h0000_0001};
        vecs[14] = '{32'h0,  4'h3, 32'h0,         32'h0};
        vecs[15] = '{32'h0,  4'h0, 32'h0,         32'h2};
        vecs[16] = '{32'h10, 4'h0, 32'h0,         32'h2};

        bif.iomem_valid = 1'b0;
        bif.iomem_addr  = 32'h0;
        bif.iomem_wstrb = 4'h0;
        bif.iomem_wdata = 32'h0;

        // Reset
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reset ser_tx", 32'(ser_tx), 32'd1);
            chk("reset ready", 32'(bif.iomem_ready), 32'd0);
            chk("reset rdata", bif.iomem_rdata, 32'h0);
        end
        resetn = 1'b1;
        @(negedge clk);

        // Register vectors
        for (int i = 0; i < 17; i++) begin
            bus_xfer(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, rd, n);
            chk($sformatf("vec%0d ack", i), 32'(n >= 1 && n <= 2), 32'd1);
            if (vecs[i].wstrb == 4'h0) chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
        end
        chk("no frame from unstrobed DATA write", rx_q.size(), 0);
        chk("ser_tx idle", 32'(ser_tx), 32'd1);

        // Single byte, DIV=4
        wr(32'h0, 4'h3, 32'd4);
        mon_div = 4;
        bus_xfer(32'h4, 4'h1, 32'hA5, rd, n);
        chk("push ack", 32'(n >= 1 && n <= 2), 32'd1);
        chk("ser_tx before start", 32'(ser_tx), 32'd1);
        @(negedge clk);
        chk("start bit one clock after push", 32'(ser_tx), 32'd0);
        wait_frames(1, 100);
        rdchk("status after single frame", 32'h8, 32'h0000_0001);
        chk("ser_tx idle after frame", 32'(ser_tx), 32'd1);

        // Back-to-back, DIV=2
        wr(32'h0, 4'h3, 32'd2);
        mon_div = 2;
        wr(32'h4, 4'h1, 32'h00);
        wr(32'h4, 4'h1, 32'hFF);
        for (int i = 0; i < 15; i++) begin
            bus_xfer(32'h8, 4'h0, 32'h0, rd, n);
            chk("b2b busy", 32'(rd[2]), 32'd1);
        end
        wait_frames(2, 200);
        chk("b2b frame gap", last_start - prev_start, 32'd20);

        // FIFO full stall, DIV=16: first byte pops at once, four more fill the FIFO, sixth stalls
        wr(32'h0, 4'h3, 32'd16);
        mon_div = 16;
        wr(32'h4, 4'h1, 32'h11);
        wr(32'h4, 4'h1, 32'h22);
        wr(32'h4, 4'h1, 32'h33);
        wr(32'h4, 4'h1, 32'h44);
        wr(32'h4, 4'h1, 32'h55);
        bus_xfer(32'h4, 4'h1, 32'h66, rd, n);
        chk("stalled write ack latency", 32'(n), 32'd153);
        @(negedge clk);
        chk("stalled ack single pulse", 32'(bif.iomem_ready), 32'd0);
        rdchk("status full", 32'h8, 32'h0000_0406);
        wait_frames(6, 1200);

        // Reset mid-frame, DIV=8: data bit 3 of 0xC3 is 0
        wr(32'h0, 4'h3, 32'd8);
        mon_div = 8;
        bus_xfer(32'h4, 4'h1, 32'hC3, rd, n);
        chk("push ack before reset", 32'(n >= 1 && n <= 2), 32'd1);
        repeat (36) @(negedge clk);
        chk("data bit3 level", 32'(ser_tx), 32'd0);
        #2 resetn = 1'b0;
        #1 chk("async reset ser_tx", 32'(ser_tx), 32'd1);
        exp_q.delete();
        rx_q.delete();
        repeat (3) @(negedge clk);
        chk("reset ready low", 32'(bif.iomem_ready), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        rdchk("status after reset", 32'h8, 32'h0000_0001);
        rdchk("div after reset", 32'h0, 32'd104);
        repeat (200) @(negedge clk);
        chk("no frame after reset", rx_q.size(), 0);
        chk("ser_tx idle after reset", 32'(ser_tx), 32'd1);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
